// File: rtl/dst_track_pipe.sv
// Destination tracker: carries dst tag / write-enable / result from ID through EX, MEM, WB,
// exposes forwarding tags and data, and handles load-use stalls, memory freezes and flushes.
module dst_track_pipe #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int R0_ZERO = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_dst_addr,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic [ADDR_W-1:0] id_p0_addr,
  input  logic [ADDR_W-1:0] id_p1_addr,
  input  logic              id_p0_used,
  input  logic              id_p1_used,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] dst_addr_EX,
  output logic              we_ex,
  output logic [DATA_W-1:0] dst_ex,
  output logic [ADDR_W-1:0] dst_addr_MEM,
  output logic              we_mem,
  output logic [DATA_W-1:0] dst_mem,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_data,
  output logic              stall_id,
  output logic [CNT_W-1:0]  load_use_cnt,
  output logic [CNT_W-1:0]  mem_wait_cnt
);

  logic              ex_valid, ex_we, ex_load;
  logic [ADDR_W-1:0] ex_dst;
  logic              mem_valid, mem_we, mem_load;
  logic [ADDR_W-1:0] mem_dst;
  logic [DATA_W-1:0] mem_alu_data;
  logic              flush_pending;

  logic wr_ex, wr_mem, freeze, src_hit, load_use, lu_stall, kill_id;

  // A write to r0 is never effective when R0_ZERO is set, so it must not be forwarded or retired.
  assign wr_ex  = ex_valid & ex_we & ~((R0_ZERO != 0) & (ex_dst == '0));
  assign wr_mem = mem_valid & mem_we & ~((R0_ZERO != 0) & (mem_dst == '0));

  assign freeze   = mem_valid & mem_load & ~mem_ready;
  assign src_hit  = (id_p0_used & (id_p0_addr == ex_dst)) | (id_p1_used & (id_p1_addr == ex_dst));
  assign load_use = id_valid & ~freeze & wr_ex & ex_load & src_hit;
  assign lu_stall = load_use & ~flush & ~flush_pending;
  assign kill_id  = flush | flush_pending | load_use;

  assign stall_id     = freeze | lu_stall;
  assign dst_addr_EX  = ex_dst;
  assign we_ex        = wr_ex & ~ex_load;
  assign dst_ex       = ex_result;
  assign dst_addr_MEM = mem_dst;
  assign dst_mem      = mem_load ? mem_rdata : mem_alu_data;
  assign we_mem       = wr_mem & (~mem_load | mem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_we         <= 1'b0;
      ex_load       <= 1'b0;
      ex_dst        <= '0;
      mem_valid     <= 1'b0;
      mem_we        <= 1'b0;
      mem_load      <= 1'b0;
      mem_dst       <= '0;
      mem_alu_data  <= '0;
      wb_we         <= 1'b0;
      wb_addr       <= '0;
      wb_data       <= '0;
      flush_pending <= 1'b0;
      load_use_cnt  <= '0;
      mem_wait_cnt  <= '0;
    end else if (freeze) begin
      // EX and MEM hold; a flush seen now is remembered until the release cycle.
      wb_we         <= 1'b0;
      flush_pending <= flush_pending | flush;
      if (mem_wait_cnt != '1) mem_wait_cnt <= mem_wait_cnt + CNT_W'(1);
    end else begin
      wb_we        <= wr_mem;
      wb_addr      <= mem_dst;
      wb_data      <= dst_mem;
      mem_valid    <= ex_valid;
      mem_we       <= ex_we;
      mem_load     <= ex_load;
      mem_dst      <= ex_dst;
      mem_alu_data <= ex_result;
      if (kill_id) begin
        ex_valid <= 1'b0;
        ex_we    <= 1'b0;
        ex_load  <= 1'b0;
        ex_dst   <= '0;
      end else begin
        ex_valid <= id_valid;
        ex_we    <= id_we;
        ex_load  <= id_is_load;
        ex_dst   <= id_dst_addr;
      end
      flush_pending <= 1'b0;
      if (lu_stall && load_use_cnt != '1) load_use_cnt <= load_use_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/dst_track_pipe.md
Name: dst_track_pipe

Overview:
- Pipeline destination tracker between decode and the operand-forwarding logic.
- Carries destination register tag, write-enable and result data from ID through EX, MEM and WB.
- Provides the EX/MEM tags and data the forwarding unit consumes, plus the write-back port to the register file.
- Detects load-use hazards, freezes on multi-cycle memory reads, and applies branch flushes.

Parameters:
- DATA_W, 16, result/data width.
- ADDR_W, 4, register address width (16 registers).
- R0_ZERO, 1, when 1, any write targeting register 0 is suppressed at every stage.
- CNT_W, 16, width of the stall performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  decode-stage instruction valid.
- id_dst_addr  in  ADDR_W  decode destination register.
- id_we  in  1  decode instruction writes a register.
- id_is_load  in  1  decode instruction is a memory load.
- id_p0_addr, id_p1_addr  in  ADDR_W  decode source registers.
- id_p0_used, id_p1_used  in  1  each source is actually read.
- ex_result  in  DATA_W  EX-stage ALU result (combinational from EX).
- mem_rdata  in  DATA_W  load data from data memory.
- mem_ready  in  1  load data valid this cycle.
- flush  in  1  branch resolved taken in EX; kill the instruction in ID.
- dst_addr_EX  out  ADDR_W  EX destination tag.
- we_ex  out  1  EX result forwardable.
- dst_ex  out  DATA_W  EX forward data.
- dst_addr_MEM  out  ADDR_W  MEM destination tag.
- we_mem  out  1  MEM result forwardable.
- dst_mem  out  DATA_W  MEM forward data.
- wb_addr  out  ADDR_W  register-file write address.
- wb_we  out  1  register-file write enable.
- wb_data  out  DATA_W  register-file write data.
- stall_id  out  1  hold PC/IF/ID this cycle.
- load_use_cnt  out  CNT_W  load-use stall cycles.
- mem_wait_cnt  out  CNT_W  memory-wait freeze cycles.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset, all stage valid bits, tags, stored data, wb_*, counters and flush_pending clear to 0. we_ex, we_mem, wb_we and stall_id read 0.
- Stage registers: EX holds {valid, dst, we, load}. MEM holds {valid, dst, we, load, alu_data}. WB holds {we, addr, data}.
- Effective write: wr(stage) = valid & we & ~(R0_ZERO & dst==0).
- Forwarding outputs:
  - we_ex = wr(EX) & ~ex_load; dst_ex = ex_result (pass-through).
  - dst_mem = mem_load ? mem_rdata : mem_alu_data.
  - we_mem = wr(MEM) & (~mem_load | mem_ready).
- freeze = mem_valid & mem_load & ~mem_ready. While frozen, EX and MEM hold, WB loads wb_we=0, stall_id=1, and mem_wait_cnt increments.
- load_use = id_valid & ~freeze & wr(EX) & ex_load & ((id_p0_used & id_p0_addr==ex_dst) | (id_p1_used & id_p1_addr==ex_dst)).
  - On load_use: stall_id=1, EX→MEM advances, a bubble (valid=0) enters EX, load_use_cnt increments.
  - The hazard resolves after exactly one bubble.
- Normal advance (no freeze, no load_use): ID→EX, EX→MEM (alu_data←ex_result), MEM→WB (wb_data←dst_mem, wb_we←wr(MEM)). Each hop takes one cycle, so ID→WB latency is 3 cycles.
- Flush:
  - Not frozen: the EX captures a bubble instead of the ID instruction. Flush overrides load_use, so stall_id=0 and load_use_cnt does not increment.
  - Frozen: flush_pending is set. On the first non-frozen cycle, EX captures a bubble and flush_pending clears.
  - flush asserted again in that release cycle yields only one bubble.
- stall_id = freeze | (load_use & ~flush & ~flush_pending).
- Counters saturate at all-ones; no wrap.
- Reset mid-freeze or mid-stall discards all in-flight instructions. No write-back occurs in the reset cycle or the following cycle.

Test Plan:
- ALU chain: ID r3←ALU (ex_result=0x1234), next ID reads r3 → next cycle we_ex=1, dst_addr_EX=3, dst_ex=0x1234, stall_id=0; wb_we=1, wb_addr=3, wb_data=0x1234 three cycles after ID.
- Load-use: load r5, next ID p0=5 used → stall_id=1 for one cycle, EX bubble; with mem_ready=1, mem_rdata=0xBEEF → we_mem=1, dst_mem=0xBEEF; load_use_cnt=1.
- Memory wait: load in MEM, mem_ready=0 for 3 cycles → stall_id=1 ×3, wb_we=0, dst_addr_MEM stable; release → wb_data=mem_rdata; mem_wait_cnt=3.
- Flush: flush with id_valid=1 → next cycle we_ex=0; flush during freeze → bubble only on the release cycle; flush+load_use same cycle → stall_id=0, load_use_cnt unchanged.
- R0 suppression: dst 0, id_we=1, R0_ZERO=1 → we_ex, we_mem, wb_we all 0 throughout; with R0_ZERO=0 → wb_we=1, wb_addr=0.
- Reset mid-freeze: assert rst during freeze → next cycle all outputs 0, counters 0, no stray write-back.
